// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data-cache storage array: flush FSM states,
// tag_o field positions and default geometry.
package dcache_pkg;

  typedef enum logic [1:0] {StIdle, StScan, StWb, StDone} flush_state_e;

  localparam int unsigned DefWays  = 4;
  localparam int unsigned DefSets  = 16;
  localparam int unsigned DefTagW  = 23;
  localparam int unsigned DefLineW = 256;

  // tag_o layout is {valid, dirty, tag}
  localparam int unsigned VALID_BIT = DefTagW + 1;
  localparam int unsigned DIRTY_BIT = DefTagW;

endpackage

// File: rtl/dcache_sram_nway_if.sv
// Access, lookup-result, flush-control and write-back signals of the cache array.
interface dcache_sram_nway_if #(
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned WAY_W  = 2
);
  logic [IDX_W-1:0]       addr_i;
  logic [TAG_W-1:0]       tag_i;
  logic [LINE_W-1:0]      data_i;
  logic                   enable_i;
  logic                   write_i;
  logic                   dirty_i;
  logic [TAG_W+1:0]       tag_o;
  logic [LINE_W-1:0]      data_o;
  logic                   hit_o;
  logic [WAY_W-1:0]       way_o;
  logic                   flush_i;
  logic                   flush_inv_i;
  logic                   busy_o;
  logic                   flush_done_o;
  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [TAG_W+IDX_W-1:0] wb_addr_o;
  logic [LINE_W-1:0]      wb_data_o;

  modport slave (
    input  addr_i, tag_i, data_i, enable_i, write_i, dirty_i, flush_i, flush_inv_i, wb_ready_i,
    output tag_o, data_o, hit_o, way_o, busy_o, flush_done_o, wb_valid_o, wb_addr_o, wb_data_o
  );

  modport master (
    output addr_i, tag_i, data_i, enable_i, write_i, dirty_i, flush_i, flush_inv_i, wb_ready_i,
    input  tag_o, data_o, hit_o, way_o, busy_o, flush_done_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/dcache_lru_ages.sv
// Per-set true-LRU age storage with update-on-access and invalid-first victim choice.
module dcache_lru_ages #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] set_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic             upd_i,
  input  logic [WAY_W-1:0] upd_way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic             found;

  always_comb begin
    age_d = age_q;
    if (upd_i) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way_i) begin
          age_d[set_i][w] = '0;
        end else if (age_q[set_i][w] < age_q[set_i][upd_way_i]) begin
          age_d[set_i][w] = age_q[set_i][w] + WAY_W'(1);
        end
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest way
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative D-cache storage with true-LRU replacement and a flush engine
// that streams dirty lines out over a valid/ready write-back port.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = DefWays,
  parameter int unsigned SETS   = DefSets,
  parameter int unsigned TAG_W  = DefTagW,
  parameter int unsigned LINE_W = DefLineW,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input logic               clk_i,
  input logic               rst_i,
  dcache_sram_nway_if.slave bus
);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-1:0]   dirty_d [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_d  [SETS][WAYS];

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             inv_q, inv_d;

  logic [WAYS-1:0]  hit_vec;
  logic             hit_any, busy, access, wr, last, adv;
  logic [WAY_W-1:0] hit_way, victim, sel_way;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[bus.addr_i][w] && (tag_q[bus.addr_i][w] == bus.tag_i);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit_any = |hit_vec;
  assign sel_way = hit_any ? hit_way : victim;
  assign busy    = (state_q != StIdle);
  assign access  = bus.enable_i && !busy;
  assign wr      = access && bus.write_i;
  assign last    = (set_q == IDX_W'(SETS - 1)) && (way_q == WAY_W'(WAYS - 1));

  dcache_lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (bus.addr_i),
    .valid_i   (valid_q[bus.addr_i]),
    .upd_i     (access && (hit_any || bus.write_i)),
    .upd_way_i (sel_way),
    .victim_o  (victim)
  );

  assign bus.hit_o        = access && hit_any;
  assign bus.way_o        = sel_way;
  assign bus.tag_o        = access ? {valid_q[bus.addr_i][sel_way], dirty_q[bus.addr_i][sel_way],
                                      tag_q[bus.addr_i][sel_way]} : '0;
  assign bus.data_o       = access ? data_q[bus.addr_i][sel_way] : '0;
  assign bus.busy_o       = busy;
  assign bus.flush_done_o = (state_q == StDone);
  assign bus.wb_valid_o   = (state_q == StWb);
  assign bus.wb_addr_o    = (state_q == StWb) ? {tag_q[set_q][way_q], set_q} : '0;
  assign bus.wb_data_o    = (state_q == StWb) ? data_q[set_q][way_q] : '0;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    inv_d   = inv_q;
    adv     = 1'b0;

    if (wr) begin
      if (hit_any) begin
        data_d[bus.addr_i][hit_way]  = bus.data_i;
        dirty_d[bus.addr_i][hit_way] = dirty_q[bus.addr_i][hit_way] | bus.dirty_i;
      end else begin
        data_d[bus.addr_i][victim]  = bus.data_i;
        tag_d[bus.addr_i][victim]   = bus.tag_i;
        valid_d[bus.addr_i][victim] = 1'b1;
        dirty_d[bus.addr_i][victim] = bus.dirty_i;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.flush_i) begin
          state_d = StScan;
          set_d   = '0;
          way_d   = '0;
          inv_d   = bus.flush_inv_i;
        end
      end
      StScan: begin
        if (valid_q[set_q][way_q] && dirty_q[set_q][way_q]) begin
          state_d = StWb;
        end else begin
          if (inv_q) valid_d[set_q][way_q] = 1'b0;
          adv = 1'b1;
        end
      end
      StWb: begin
        if (bus.wb_ready_i) begin
          dirty_d[set_q][way_q] = 1'b0;
          if (inv_q) valid_d[set_q][way_q] = 1'b0;
          state_d = StScan;
          adv     = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Cursor walks ways within a set, then moves to the next set
    if (adv) begin
      if (last) begin
        state_d = StDone;
      end else begin
        way_d = way_q + WAY_W'(1);
        if (way_q == WAY_W'(WAYS - 1)) set_d = set_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      state_q <= StIdle;
      set_q   <= '0;
      way_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Bench for dcache_sram_nway: table-driven lookup/fill/LRU vectors through a scoreboard,
// plus flush, invalidate-flush and reset-during-write-back sequences.
module tb_dcache_sram_nway;
  import dcache_pkg::*;

  typedef struct {
    logic         en, wr, dty;
    logic [3:0]   set;
    logic [22:0]  tag;
    logic [255:0] data;
    logic         exp_hit;
    logic [1:0]   exp_way;
    logic [24:0]  exp_tag;
    logic [255:0] exp_data;
  } vec_t;

  typedef struct {
    logic         hit;
    logic [1:0]   way;
    logic [24:0]  tag;
    logic [255:0] data;
  } exp_t;

  typedef struct {
    logic [26:0]  addr;
    logic [255:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   wbv_cnt = 0;

  exp_t sbq[$];
  wb_t  wbq[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  dcache_sram_nway_if #(.TAG_W(23), .LINE_W(256), .IDX_W(4), .WAY_W(2)) dif ();

  dcache_sram_nway #(.WAYS(4), .SETS(16), .TAG_W(23), .LINE_W(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dif)
  );

  always @(negedge clk) begin
    if (dif.flush_done_o) done_cnt <= done_cnt + 1;
    if (dif.wb_valid_o)   wbv_cnt  <= wbv_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [24:0] tv(input logic v, input logic d, input logic [22:0] t);
    return {v, d, t};
  endfunction

  function automatic vec_t mk(input logic en, input logic wr, input logic dty, input logic [3:0] s,
                              input logic [22:0] t, input logic [255:0] d, input logic eh,
                              input logic [1:0] ew, input logic [24:0] et, input logic [255:0] ed);
    vec_t v;
    v.en = en; v.wr = wr; v.dty = dty; v.set = s; v.tag = t; v.data = d;
    v.exp_hit = eh; v.exp_way = ew; v.exp_tag = et; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [299:0] act, input logic [299:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    dif.enable_i = v.en;
    dif.write_i  = v.wr;
    dif.dirty_i  = v.dty;
    dif.addr_i   = v.set;
    dif.tag_i    = v.tag;
    dif.data_i   = v.data;
    e.hit = v.exp_hit; e.way = v.exp_way; e.tag = v.exp_tag; e.data = v.exp_data;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    check($sformatf("vec%0d hit", idx), dif.hit_o, e.hit);
    check($sformatf("vec%0d way", idx), dif.way_o, e.way);
    check($sformatf("vec%0d tag", idx), dif.tag_o, e.tag);
    check($sformatf("vec%0d data", idx), dif.data_o, e.data);
    @(posedge clk);
    #1;
    dif.enable_i = 1'b0;
    dif.write_i  = 1'b0;
  endtask

  task automatic fill(input logic [3:0] s, input logic [22:0] t, input logic d);
    dif.enable_i = 1'b1; dif.write_i = 1'b1; dif.dirty_i = d;
    dif.addr_i = s; dif.tag_i = t; dif.data_i = pat(t[7:0]);
    @(posedge clk);
    #1;
    dif.enable_i = 1'b0; dif.write_i = 1'b0;
  endtask

  task automatic lookup(input string nm, input logic [3:0] s, input logic [22:0] t,
                        input logic eh, input logic [24:0] et);
    dif.enable_i = 1'b1; dif.write_i = 1'b0; dif.addr_i = s; dif.tag_i = t;
    @(negedge clk);
    check({nm, " hit"}, dif.hit_o, eh);
    check({nm, " tag"}, dif.tag_o, et);
    @(posedge clk);
    #1;
    dif.enable_i = 1'b0;
  endtask

  task automatic pulse_flush(input logic inv);
    dif.flush_i = 1'b1; dif.flush_inv_i = inv;
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0; dif.flush_inv_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_wb(output logic got);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (dif.wb_valid_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!dif.busy_o) break;
    end
    check("flush ends", dif.busy_o, 1'b0);
  endtask

  initial begin
    logic got;
    int   base_done, base_wbv, busy_cycles;
    wb_t  w;

    dif.addr_i = '0; dif.tag_i = '0; dif.data_i = '0; dif.enable_i = 1'b0;
    dif.write_i = 1'b0; dif.dirty_i = 1'b0; dif.flush_i = 1'b0; dif.flush_inv_i = 1'b0;
    dif.wb_ready_i = 1'b0;

    vecs[0]  = mk(1, 1, 0, 3, 23'h10, pat(8'h10), 0, 0, '0, '0);
    vecs[1]  = mk(1, 1, 0, 3, 23'h11, pat(8'h11), 0, 1, '0, '0);
    vecs[2]  = mk(1, 1, 0, 3, 23'h12, pat(8'h12), 0, 2, '0, '0);
    vecs[3]  = mk(1, 1, 0, 3, 23'h13, pat(8'h13), 0, 3, '0, '0);
    vecs[4]  = mk(1, 0, 0, 3, 23'h11, '0, 1, 1, tv(1, 0, 23'h11), pat(8'h11));
    vecs[5]  = mk(1, 0, 0, 3, 23'h10, '0, 1, 0, tv(1, 0, 23'h10), pat(8'h10));
    vecs[6]  = mk(1, 0, 0, 3, 23'h12, '0, 1, 2, tv(1, 0, 23'h12), pat(8'h12));
    vecs[7]  = mk(1, 0, 0, 3, 23'h13, '0, 1, 3, tv(1, 0, 23'h13), pat(8'h13));
    vecs[8]  = mk(1, 1, 0, 3, 23'h20, pat(8'h20), 0, 1, tv(1, 0, 23'h11), pat(8'h11));
    vecs[9]  = mk(1, 0, 0, 3, 23'h11, '0, 0, 0, tv(1, 0, 23'h10), pat(8'h10));
    vecs[10] = mk(1, 0, 0, 3, 23'h20, '0, 1, 1, tv(1, 0, 23'h20), pat(8'h20));
    vecs[11] = mk(1, 1, 0, 5, 23'h7, pat(8'h5A), 0, 0, '0, '0);
    vecs[12] = mk(1, 1, 1, 5, 23'h7, pat(8'hA5), 1, 0, tv(1, 0, 23'h7), pat(8'h5A));
    vecs[13] = mk(1, 0, 0, 5, 23'h7, '0, 1, 0, tv(1, 1, 23'h7), pat(8'hA5));
    vecs[14] = mk(0, 0, 0, 5, 23'h7, '0, 0, 0, '0, '0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: tag 0 must not hit an invalid line
    dif.enable_i = 1'b1; dif.addr_i = 4'd0; dif.tag_i = '0;
    @(negedge clk);
    check("rst busy", dif.busy_o, 1'b0);
    check("rst wb_valid", dif.wb_valid_o, 1'b0);
    check("rst done", dif.flush_done_o, 1'b0);
    check("rst hit", dif.hit_o, 1'b0);
    check("rst tag", dif.tag_o, '0);
    @(posedge clk);
    #1;
    dif.enable_i = 1'b0;

    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Flush with two dirty lines, consumer stalls each write-back
    do_reset();
    fill(4'd2, 23'h31, 1'b1);
    fill(4'd9, 23'h40, 1'b0);
    fill(4'd9, 23'h41, 1'b0);
    fill(4'd9, 23'h42, 1'b0);
    fill(4'd9, 23'h43, 1'b1);
    w.addr = {23'h31, 4'd2}; w.data = pat(8'h31); wbq.push_back(w);
    w.addr = {23'h43, 4'd9}; w.data = pat(8'h43); wbq.push_back(w);
    base_done = done_cnt;
    pulse_flush(1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_wb(got);
      check($sformatf("wb%0d seen", k), got, 1'b1);
      if (!got) break;
      w = wbq.pop_front();
      for (int s = 0; s < 4; s++) begin
        check($sformatf("wb%0d valid", k), dif.wb_valid_o, 1'b1);
        check($sformatf("wb%0d addr", k), dif.wb_addr_o, w.addr);
        check($sformatf("wb%0d data", k), dif.wb_data_o, w.data);
        if (s < 3) @(negedge clk);
      end
      dif.wb_ready_i = 1'b1;
      @(posedge clk);
      #1;
      dif.wb_ready_i = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    check("flush1 done pulses", done_cnt - base_done, 1);
    lookup("post flush1 s2", 4'd2, 23'h31, 1'b1, tv(1, 0, 23'h31));
    lookup("post flush1 s9", 4'd9, 23'h43, 1'b1, tv(1, 0, 23'h43));

    // Invalidating flush of a clean array
    base_done = done_cnt;
    base_wbv  = wbv_cnt;
    busy_cycles = 0;
    pulse_flush(1'b1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (dif.busy_o) busy_cycles++;
      else break;
    end
    check("inv flush busy cycles", busy_cycles, 65);
    @(negedge clk);
    check("inv flush wb_valid count", wbv_cnt - base_wbv, 0);
    check("inv flush done pulses", done_cnt - base_done, 1);
    lookup("post inv s2", 4'd2, 23'h31, 1'b0, tv(0, 0, 23'h31));
    lookup("post inv s9", 4'd9, 23'h43, 1'b0, tv(0, 0, 23'h40));

    // Reset while a write-back is pending
    fill(4'd0, 23'h55, 1'b1);
    pulse_flush(1'b0);
    wait_wb(got);
    check("rst-wb seen", got, 1'b1);
    base_done = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst-wb wb_valid", dif.wb_valid_o, 1'b0);
    check("rst-wb busy", dif.busy_o, 1'b0);
    repeat (70) @(negedge clk);
    check("rst-wb no done", done_cnt - base_done, 0);
    @(posedge clk);
    #1;
    lookup("rst-wb s0", 4'd0, 23'h55, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
